sq_norm_acc: RTL and testbench

- Streaming sum-of-squares accumulator that produces ||A||^2 for one vector at a time.
- Sits directly upstream of the inverse-norm stage: its d_out/valid_out drive that stage's d_in/valid_in.
- Accepts one signed element per cycle, with no backpressure. Back-to-back vectors run with zero bubble cycles.

---
 rtl/sq_norm_acc.sv | 124 ++++++++++++
 tb/tb_sq_norm_acc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_norm_acc.sv
// rtl/sq_norm_acc.sv - streaming sum-of-squares accumulator; SQ_NORM_ZERO_DETECT_EN adds zero_out
module sq_norm_acc #(
    parameter int ELEM_W  = 16,
    parameter int VEC_LEN = 64,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     valid_in,
    input  logic signed [ELEM_W-1:0] elem_in,
    input  logic                     last_in,
    input  logic                     clear_in,
    output logic [31:0]              d_out,
    output logic                     valid_out,
    output logic [CNT_W-1:0]         len_out,
    output logic                     sat_out,
    output logic                     trunc_out
`ifdef SQ_NORM_ZERO_DETECT_EN
    ,
    output logic                     zero_out
`endif
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        count;
    logic                    limit;
    logic signed [2*ELEM_W-1:0] prod;

    // Stage-1 registers; sq1 top bit is always zero since |elem|^2 <= 2^(2*ELEM_W-2)
    logic [2*ELEM_W-1:0]     sq1;
    logic                    v1, l1, t1;

    logic [31:0]             acc;
    logic                    sat;
    logic [CNT_W-1:0]        n2;

    logic [31:0]             base;
    logic [32:0]             sum33;
    logic                    sat_hit;
    logic [31:0]             nsum;
    logic                    emit;
    logic                    acc_en;

    assign prod  = elem_in * elem_in;
    assign limit = (count == CNT_W'(VEC_LEN - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
            sq1   <= '0;
            v1    <= 1'b0;
            l1    <= 1'b0;
            t1    <= 1'b0;
        end else if (clear_in) begin
            count <= '0;
            v1    <= 1'b0;
        end else begin
            v1 <= valid_in;
            if (valid_in) begin
                sq1   <= prod;
                l1    <= last_in | limit;
                t1    <= limit & ~last_in;
                count <= (last_in | limit) ? '0 : count + 1'b1;
            end
        end
    end

    always_comb begin
        base     = (state == IDLE) ? 32'd0 : acc;
        sum33    = {1'b0, base} + {{(33 - 2*ELEM_W){1'b0}}, sq1};
        sat_hit  = sum33[32] | sat;
        nsum     = sat_hit ? 32'hFFFF_FFFF : sum33[31:0];
        emit     = v1 & l1 & ~clear_in;
        acc_en   = v1 & ~l1 & ~clear_in;
        state_nx = state;
        if (clear_in)
            state_nx = IDLE;
        else if (v1)
            state_nx = l1 ? IDLE : ACCUM;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            acc       <= '0;
            sat       <= 1'b0;
            n2        <= '0;
            d_out     <= '0;
            valid_out <= 1'b0;
            len_out   <= '0;
            sat_out   <= 1'b0;
            trunc_out <= 1'b0;
`ifdef SQ_NORM_ZERO_DETECT_EN
            zero_out  <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            valid_out <= emit;
            if (clear_in) begin
                acc <= '0;
                sat <= 1'b0;
                n2  <= '0;
            end else if (emit) begin
                d_out     <= nsum;
                len_out   <= n2 + 1'b1;
                sat_out   <= sat_hit;
                trunc_out <= t1;
`ifdef SQ_NORM_ZERO_DETECT_EN
                zero_out  <= (nsum == 32'd0);
`endif
                acc       <= '0;
                sat       <= 1'b0;
                n2        <= '0;
            end else if (acc_en) begin
                acc <= nsum;
                sat <= sat_hit;
                n2  <= n2 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sq_norm_acc.sv
// tb/tb_sq_norm_acc.sv - bench for sq_norm_acc: directed table, VEC_LEN=4 limit, reset, random vs model
module tb_sq_norm_acc;

    logic               clk = 1'b0;
    logic               nrst;
    logic               valid_in, last_in, clear_in;
    logic signed [15:0] elem_in;

    logic [31:0] d_a, d_b;
    logic        valid_a, valid_b, sat_a, sat_b, trunc_a, trunc_b;
    logic [6:0]  len_a;
    logic [2:0]  len_b;
`ifdef SQ_NORM_ZERO_DETECT_EN
    logic        zero_a, zero_b;
`endif

    sq_norm_acc #(.ELEM_W(16), .VEC_LEN(64)) dut_a (
        .clk(clk), .nrst(nrst), .valid_in(valid_in), .elem_in(elem_in),
        .last_in(last_in), .clear_in(clear_in), .d_out(d_a), .valid_out(valid_a),
        .len_out(len_a), .sat_out(sat_a), .trunc_out(trunc_a)
`ifdef SQ_NORM_ZERO_DETECT_EN
        , .zero_out(zero_a)
`endif
    );

    sq_norm_acc #(.ELEM_W(16), .VEC_LEN(4)) dut_b (
        .clk(clk), .nrst(nrst), .valid_in(valid_in), .elem_in(elem_in),
        .last_in(last_in), .clear_in(clear_in), .d_out(d_b), .valid_out(valid_b),
        .len_out(len_b), .sat_out(sat_b), .trunc_out(trunc_b)
`ifdef SQ_NORM_ZERO_DETECT_EN
        , .zero_out(zero_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [31:0] d;
        int          len;
        logic        sat;
        logic        trunc;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        v;
        int          e;
        logic        l;
        logic        c;
        logic        ev;
        logic [31:0] d;
        int          len;
        logic        sat;
        logic        trunc;
    } row_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    exp_t        expq[$];
    row_t        tbl[$];
    longint      psum[2];
    int          plen[2];
    logic [31:0] held_d[2];

    function automatic logic [63:0] pack(logic v, logic [31:0] d, int len, logic s, logic t);
        logic [7:0] l8;
        l8 = len[7:0];
        return {21'd0, v, d, l8, s, t};
    endfunction

    function automatic logic [63:0] outs(int k);
        if (k == 0) return pack(valid_a, d_a, int'(len_a), sat_a, trunc_a);
        return pack(valid_b, d_b, int'(len_b), sat_b, trunc_b);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        for (int k = 0; k < 2; k++) begin
            psum[k] = 0; plen[k] = 0; held_d[k] = 32'd0;
        end
    endtask

    // Reference: an accepted element joins the open vector; the vector closes on last or at
    // its length limit and its result is due two clock edges later unless a clear lands first.
    task automatic model_in(input logic v, input int e, input logic l, input logic c);
        int   p;
        exp_t x;
        p = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            int vl;
            vl = (k == 0) ? 64 : 4;
            if (c) begin
                psum[k] = 0; plen[k] = 0;
                for (int i = expq.size() - 1; i >= 0; i--)
                    if (expq[i].k == k && expq[i].cyc == p) expq.delete(i);
            end else if (v) begin
                psum[k] += longint'(e) * longint'(e);
                plen[k]++;
                if (l || plen[k] == vl) begin
                    x.k     = k;
                    x.d     = (psum[k] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : psum[k][31:0];
                    x.len   = plen[k];
                    x.sat   = (psum[k] > 64'hFFFF_FFFF);
                    x.trunc = !l;
                    x.cyc   = p + 1;
                    expq.push_back(x);
                    psum[k] = 0; plen[k] = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < expq.size(); i++)
                if (idx < 0 && expq[i].k == k && expq[i].cyc == cyc) idx = i;
            if (idx >= 0) begin
                chk($sformatf("model_emit_dut%0d", k), outs(k),
                    pack(1'b1, expq[idx].d, expq[idx].len, expq[idx].sat, expq[idx].trunc));
                held_d[k] = expq[idx].d;
                expq.delete(idx);
            end else begin
                logic [63:0] o;
                o = outs(k);
                chk($sformatf("model_idle_dut%0d", k), {o[42], o[41:10]}, {1'b0, held_d[k]});
            end
        end
    endtask

    task automatic step(input logic v, input int e, input logic l, input logic c);
        valid_in = v; elem_in = 16'(e); last_in = l; clear_in = c;
        model_in(v, e, l, c);
        @(posedge clk);
        cyc++;
        #1;
        model_check();
    endtask

    task automatic add(input logic v, input int e, input logic l, input logic c, input logic ev,
                       input logic [31:0] d, input int len, input logic s, input logic t);
        row_t r;
        r.v = v; r.e = e; r.l = l; r.c = c; r.ev = ev; r.d = d; r.len = len; r.sat = s; r.trunc = t;
        tbl.push_back(r);
    endtask

    initial begin
        nrst = 1'b0; valid_in = 1'b0; elem_in = '0; last_in = 1'b0; clear_in = 1'b0;
        model_reset();
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        chk("reset_a", outs(0), 64'd0);
        chk("reset_b", outs(1), 64'd0);
        nrst = 1'b1;

        // inputs this cycle | outputs expected on dut_a after this cycle's edge
        add(1, 3, 0, 0, 0, 0, 0, 0, 0);
        add(1, 4, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 25, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, -32768, 0, 0, 0, 0, 0, 0, 0);
        add(1, -32768, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 32'hFFFF_FFFF, 5, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 2, 1, 0, 1, 1, 1, 0, 0);
        add(1, -3, 1, 0, 1, 4, 1, 0, 0);
        add(0, 0, 0, 0, 1, 9, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0, 0);
        add(1, 6, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 13, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].e, tbl[i].l, tbl[i].c);
            if (tbl[i].ev)
                chk($sformatf("table_row%0d", i), outs(0),
                    pack(1'b1, tbl[i].d, tbl[i].len, tbl[i].sat, tbl[i].trunc));
            else
                chk($sformatf("table_row%0d_novalid", i), {63'd0, valid_a}, 64'd0);
        end

        // VEC_LEN=4 forced termination on dut_b
        for (int i = 0; i < 6; i++) begin
            step(1, 2, 0, 0);
            if (i == 4) chk("veclen_trunc", outs(1), pack(1'b1, 16, 4, 1'b0, 1'b1));
        end
        step(1, 2, 1, 0);
        step(0, 0, 0, 0);
        chk("veclen_after", outs(1), pack(1'b1, 12, 3, 1'b0, 1'b0));

        // Asynchronous reset mid-vector
        step(1, 7, 0, 0);
        step(1, 7, 0, 0);
        nrst = 1'b0;
        valid_in = 1'b0; last_in = 1'b0;
        #1;
        chk("async_reset_a", outs(0), 64'd0);
        chk("async_reset_b", outs(1), 64'd0);
        model_reset();
        @(posedge clk); cyc++;
        #1;
        nrst = 1'b1;
        step(1, 2, 1, 0);
        step(0, 0, 0, 0);
        chk("post_reset_a", outs(0), pack(1'b1, 4, 1, 1'b0, 1'b0));

        // Randomised traffic: first short vectors, then sparse last to reach VEC_LEN=64
        for (int i = 0; i < 4000; i++) begin
            int  e;
            int  sel;
            logic l;
            sel = $urandom_range(0, 7);
            if (sel == 0)      e = -32768;
            else if (sel == 1) e = 32767;
            else if (sel < 4)  e = $urandom_range(0, 20) - 10;
            else               e = $urandom_range(0, 65535) - 32768;
            l = (i < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 89) == 0);
            step($urandom_range(0, 3) != 0, e, l, $urandom_range(0, 59) == 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("no_overdue_results", 64'(expq.size()), 64'd0);

`ifdef SQ_NORM_ZERO_DETECT_EN
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("zero_detect", {62'd0, zero_a, valid_a}, 64'd3);
        chk("zero_detect_d", 64'(d_a), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
